// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Results are registered and held until the next operation completes.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             divByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == CW'(1));

    // rem_w < dvs holds throughout, so trial[WIDTH] is an exact borrow flag
    // even when the shifted remainder overflows WIDTH bits.
    always_comb begin
        shifted   = {rem_w, dvd[WIDTH-1]};
        trial     = shifted - {1'b0, dvs};
        no_borrow = ~trial[WIDTH];
        rem_nx    = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nx    = {quo_w[WIDTH-2:0], no_borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (B != '0) ? RUN : DONE;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = (B != '0) ? RUN : DONE;
                else       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd       <= '0;
            dvs       <= '0;
            rem_w     <= '0;
            quo_w     <= '0;
            cnt       <= '0;
            Q         <= '0;
            R         <= '0;
            divByZero <= 1'b0;
        end else if (accept) begin
            dvd   <= A;
            dvs   <= B;
            rem_w <= '0;
            quo_w <= '0;
            if (B != '0) begin
                cnt <= CW'(WIDTH);
            end else begin
                // Divide by zero completes immediately with a saturated quotient.
                cnt       <= '0;
                Q         <= '1;
                R         <= A;
                divByZero <= 1'b1;
            end
        end else if (state == RUN) begin
            dvd   <= {dvd[WIDTH-2:0], 1'b0};
            rem_w <= rem_nx;
            quo_w <= quo_nx;
            cnt   <= cnt - CW'(1);
            if (last_step) begin
                Q         <= quo_nx;
                R         <= rem_nx;
                divByZero <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand, quotient and remainder width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  request a new division; sampled on the rising edge of clk.
REQ-005 SHALL have port A  input  WIDTH  unsigned dividend; sampled with start.
REQ-006 SHALL have port B  input  WIDTH  unsigned divisor; sampled with start.
REQ-007 SHALL have port Q  output  WIDTH  quotient, registered.
REQ-008 SHALL have port R  output  WIDTH  remainder, registered.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse when Q/R/divByZero become valid.
REQ-011 SHALL have port divByZero  output  1  high with the result when the latched B was zero.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance, latch A and B and clear the internal quotient/remainder working registers.
REQ-014 SHALL move from IDLE or DONE to RUN on an accepted start when B != 0, and load an iteration counter with WIDTH.
REQ-015 SHALL move from IDLE or DONE to DONE on an accepted start when B == 0, with Q = all ones, R = A, and divByZero = 1.
REQ-016 SHALL perform one restoring step per RUN cycle, MSB first: remainder shifted left with the next dividend bit inserted, then trial = remainder - divisor at WIDTH+1 bits.
REQ-017 SHALL, in each step, set the quotient bit to 1 and keep trial when trial has no borrow; otherwise set the quotient bit to 0 and keep the shifted remainder.
REQ-018 SHALL move from RUN to DONE after exactly WIDTH steps, and update Q and R on that same edge.
REQ-019 SHALL give a latency, from the edge that samples start, of WIDTH+1 edges to done high for B != 0, and 1 edge for B == 0.
REQ-020 SHALL assert busy exactly while in RUN.
REQ-021 SHALL assert done exactly while in DONE; DONE lasts one cycle.
REQ-022 SHALL return from DONE to IDLE unless start is high in DONE, in which case the new operation is accepted per REQ-013..015.
REQ-023 SHALL ignore start while in RUN; latched operands and progress are unaffected.
REQ-024 SHALL hold Q, R and divByZero from DONE until the next DONE entry.
REQ-025 SHALL clear divByZero when any result with B != 0 is produced.
REQ-026 SHALL guarantee Q*B + R == A and R < B for every B != 0.
REQ-027 SHALL never change A/B sampling behaviour or Q/R because of input changes during RUN.

Reset
REQ-028 SHALL, while rst_n is low, immediately force state IDLE, with Q = 0, R = 0, busy = 0, done = 0, divByZero = 0, and counter and working registers = 0.
REQ-029 SHALL abandon an in-flight RUN on reset with no done pulse; the first start after rst_n rises is accepted normally.

Verification
REQ-030 SHALL pass: A=13, B=3, start one cycle -> busy high 4 cycles, done at edge 5, Q=4, R=1, divByZero=0.
REQ-031 SHALL pass: A=15, B=1 -> Q=15, R=0; A=3, B=9 -> Q=0, R=3; A=0, B=5 -> Q=0, R=0.
REQ-032 SHALL pass: A=7, B=0 -> done at edge 1, busy never high, Q=15, R=7, divByZero=1; then A=6, B=2 -> Q=3, R=0, divByZero=0.
REQ-033 SHALL pass: start with A=9, B=2 held, a second start with A=1, B=1 pulsed in cycle 2 of RUN -> result Q=4, R=1, one done pulse only.
REQ-034 SHALL pass: rst_n low during RUN cycle 3 -> all outputs 0 asynchronously, no done; after release, A=10, B=4 -> Q=2, R=2.
REQ-035 SHALL pass: start held high across DONE (back-to-back) -> second operation starts on the done edge, done pulses for both; exhaustive 16x16 sweep satisfies REQ-026.
